// File: rtl/m_useq.sv
// Microcode sequencer: picks the next microcode address from dispatch,
// repeat-loop, conditional branch or the microword's next-address field.
module m_useq #(
  parameter logic [7:0] IRQ_VEC = 8'hF0,
  parameter logic [7:0] ILL_VEC = 8'hF8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       progress_ucode,
  input  logic [7:0] ucode_next,
  input  logic       ctl_dispatch,
  input  logic       ctl_branch,
  input  logic       cond,
  input  logic       ctl_loop,
  input  logic [4:0] cnt_init,
  input  logic [6:0] instr_op,
  input  logic       irq_pending,
  output logic [7:0] minx,
  output logic       loop_active,
  output logic       irq_ack,
  output logic       trap_illegal
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOOP = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] minx_q, minx_d;
  logic [4:0] cnt_q, cnt_d;
  logic       irq_ack_q, irq_ack_d;
  logic       trap_q, trap_d;

  // Only 32-bit base opcodes with a microcode routine are dispatchable.
  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    if (op[1:0] != 2'b11) begin
      ok = 1'b0;
    end else begin
      case (op[6:2])
        5'b00000, 5'b00011, 5'b00100, 5'b00101,
        5'b01000, 5'b01100, 5'b01101, 5'b11000,
        5'b11001, 5'b11011, 5'b11100: ok = 1'b1;
        default:                      ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Next-state and next-address selection.
  always_comb begin
    state_d   = state_q;
    minx_d    = minx_q;
    cnt_d     = cnt_q;
    irq_ack_d = 1'b0;
    trap_d    = 1'b0;
    if (progress_ucode) begin
      case (state_q)
        ST_RUN: begin
          if (ctl_dispatch) begin
            if (irq_pending) begin
              minx_d    = IRQ_VEC;
              irq_ack_d = 1'b1;
            end else if (op_legal(instr_op)) begin
              minx_d = {1'b1, instr_op[6:2], 2'b00};
            end else begin
              minx_d = ILL_VEC;
              trap_d = 1'b1;
            end
          end else if (ctl_loop) begin
            if (cnt_init == 5'd0) begin
              minx_d = ucode_next;
            end else begin
              cnt_d   = cnt_init;
              state_d = ST_LOOP;
            end
          end else if (ctl_branch) begin
            if (cond) begin
              minx_d = ucode_next;
            end else begin
              minx_d = minx_q + 8'd1;
            end
          end else begin
            minx_d = ucode_next;
          end
        end
        ST_LOOP: begin
          // A zero count cannot occur in LOOP; treat it as the last pass anyway.
          if (cnt_q <= 5'd1) begin
            cnt_d   = 5'd0;
            minx_d  = ucode_next;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 5'd0;
          minx_d  = 8'h00;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      minx_q    <= 8'h00;
      cnt_q     <= 5'd0;
      irq_ack_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      minx_q    <= minx_d;
      cnt_q     <= cnt_d;
      irq_ack_q <= irq_ack_d;
      trap_q    <= trap_d;
    end
  end

  assign minx         = minx_q;
  assign loop_active  = (state_q == ST_LOOP);
  assign irq_ack      = irq_ack_q;
  assign trap_illegal = trap_q;

endmodule

// File: tb/tb_m_useq.sv
// Directed bench for m_useq: stimulus pushes expectations, a monitor pops
// and compares one entry per clock after the edge that consumes the stimulus.
module tb_m_useq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       progress_ucode = 1'b0;
  logic [7:0] ucode_next = 8'h00;
  logic       ctl_dispatch = 1'b0;
  logic       ctl_branch = 1'b0;
  logic       cond = 1'b0;
  logic       ctl_loop = 1'b0;
  logic [4:0] cnt_init = 5'd0;
  logic [6:0] instr_op = 7'd0;
  logic       irq_pending = 1'b0;
  logic [7:0] minx;
  logic       loop_active, irq_ack, trap_illegal;

  typedef struct {
    string      name;
    logic [7:0] minx;
    logic       la;
    logic       ack;
    logic       trap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  m_useq dut (
    .clk(clk), .rst_n(rst_n), .progress_ucode(progress_ucode),
    .ucode_next(ucode_next), .ctl_dispatch(ctl_dispatch),
    .ctl_branch(ctl_branch), .cond(cond), .ctl_loop(ctl_loop),
    .cnt_init(cnt_init), .instr_op(instr_op), .irq_pending(irq_pending),
    .minx(minx), .loop_active(loop_active), .irq_ack(irq_ack),
    .trap_illegal(trap_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_now(input string name, input logic [7:0] em, input logic el,
                           input logic ea, input logic et);
    n_tests++;
    if (minx !== em || loop_active !== el || irq_ack !== ea || trap_illegal !== et) begin
      n_fail++;
      $display("FAIL %s: got minx=%h la=%b ack=%b trap=%b, want minx=%h la=%b ack=%b trap=%b",
               name, minx, loop_active, irq_ack, trap_illegal, em, el, ea, et);
    end
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now(e.name, e.minx, e.la, e.ack, e.trap);
      end
    end
  end

  // One clock of stimulus, driven on the falling edge.
  task automatic step(input string name, input logic prog, input logic disp,
                      input logic br, input logic cd, input logic lp,
                      input logic [4:0] ci, input logic [6:0] op, input logic irq,
                      input logic [7:0] nxt, input logic [7:0] em, input logic el,
                      input logic ea, input logic et);
    exp_t e;
    @(negedge clk);
    progress_ucode = prog; ctl_dispatch = disp; ctl_branch = br; cond = cd;
    ctl_loop = lp; cnt_init = ci; instr_op = op; irq_pending = irq; ucode_next = nxt;
    e.name = name; e.minx = em; e.la = el; e.ack = ea; e.trap = et;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      #2;
      budget++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #3;
    check_now("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_now("after_release", 8'h00, 1'b0, 1'b0, 1'b0);
    //                     prog disp br cd lp cnt    op          irq next   minx  la ack trap
    step("first_next",     1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h37, 8'h37, 0, 0, 0);
    step("disp_legal",     1, 1, 0, 0, 0, 5'd0, 7'b0110011, 0, 8'h00, 8'hB0, 0, 0, 0);
    step("disp_irq",       1, 1, 0, 0, 0, 5'd0, 7'b1111111, 1, 8'h00, 8'hF0, 0, 1, 0);
    step("irq_pulse_end",  1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'hFF, 8'hFF, 0, 0, 0);
    step("disp_illegal",   1, 1, 0, 0, 0, 5'd0, 7'b1111111, 0, 8'h00, 8'hF8, 0, 0, 1);
    step("trap_pulse_end", 1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'hFF, 8'hFF, 0, 0, 0);
    step("branch_wrap",    1, 0, 1, 0, 0, 5'd0, 7'b0000000, 0, 8'h12, 8'h00, 0, 0, 0);
    step("branch_taken",   1, 0, 1, 1, 0, 5'd0, 7'b0000000, 0, 8'h12, 8'h12, 0, 0, 0);
    step("branch_inc",     1, 0, 1, 0, 0, 5'd0, 7'b0000000, 0, 8'h99, 8'h13, 0, 0, 0);
    step("disp_irq2",      1, 1, 0, 0, 0, 5'd0, 7'b0110011, 1, 8'h00, 8'hF0, 0, 1, 0);
    step("freeze",         0, 1, 0, 0, 0, 5'd0, 7'b0110011, 1, 8'h55, 8'hF0, 0, 0, 0);
    step("illegal_lowbits",1, 1, 0, 0, 0, 5'd0, 7'b0110010, 0, 8'h00, 8'hF8, 0, 0, 1);
    step("illegal_major",  1, 1, 0, 0, 0, 5'd0, 7'b0000111, 0, 8'h00, 8'hF8, 0, 0, 1);
    step("disp_priority",  1, 1, 1, 1, 1, 5'd3, 7'b0000011, 0, 8'h22, 8'h80, 0, 0, 0);
    step("disp_jal",       1, 1, 0, 0, 0, 5'd0, 7'b1101111, 0, 8'h00, 8'hEC, 0, 0, 0);
    step("loop_zero",      1, 0, 1, 0, 1, 5'd0, 7'b0000000, 0, 8'h55, 8'h55, 0, 0, 0);
    step("pre_loop",       1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h20, 8'h20, 0, 0, 0);
    step("loop_enter",     1, 0, 0, 0, 1, 5'd3, 7'b0000000, 0, 8'h40, 8'h20, 1, 0, 0);
    step("loop_ignore",    1, 1, 1, 1, 1, 5'd7, 7'b1111111, 1, 8'h40, 8'h20, 1, 0, 0);
    step("loop_freeze",    0, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h40, 8'h20, 1, 0, 0);
    step("loop_cnt1",      1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h40, 8'h20, 1, 0, 0);
    step("loop_exit",      1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h40, 8'h40, 0, 0, 0);
    step("loop2_enter",    1, 0, 0, 0, 1, 5'd5, 7'b0000000, 0, 8'h77, 8'h40, 1, 0, 0);
    step("loop2_run",      1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h77, 8'h40, 1, 0, 0);
    drain();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_mid_loop", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_now("after_loop_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    step("resume_next",    1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h66, 8'h66, 0, 0, 0);
    step("idle",           1, 0, 0, 0, 0, 5'd0, 7'b0000000, 0, 8'h01, 8'h01, 0, 0, 0);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
